image_frame_assembler: RTL and testbench

- Sits directly downstream of the SPI peripheral receive stage and consumes its byte stream through the spi_byte_valid / byte_taken handshake.
- Packs a fixed-length frame of IMG_BYTES bytes into a flat binary pixel image of IMG_W x IMG_H bits.
- Presents the completed image to the BNN inference core and holds it stable until the core acknowledges it.
- Detects stalled partial frames and overflow bytes.

---
 rtl/image_frame_assembler.sv | 104 ++++++++++
 tb/tb_image_frame_assembler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_frame_assembler.sv
// Packs a fixed-length SPI byte stream into a flat binary image for the BNN core.
// Holds the finished image until acknowledged; flags stalled frames and overflow bytes.
module image_frame_assembler #(
  parameter int IMG_W          = 30,
  parameter int IMG_H          = 30,
  parameter int IMG_BYTES      = 113,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [7:0]                         spi_rx_data,
  input  logic                               spi_byte_valid,
  output logic                               byte_taken,
  output logic [IMG_W*IMG_H-1:0]             img_data,
  output logic                               img_valid,
  input  logic                               img_ack,
  output logic                               frame_err,
  output logic                               overflow,
  output logic [$clog2(IMG_BYTES+1)-1:0]     byte_cnt
);

  localparam int PIX = IMG_W * IMG_H;
  localparam int CW  = $clog2(IMG_BYTES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] FULL    = 1'b1;

  logic [0:0]     state;
  logic           valid_q;
  logic [TW-1:0]  tcnt;
  logic           acc;
  logic           last;
  logic [7:0]     rev;
  logic [PIX-1:0] ins;

  assign acc  = spi_byte_valid & ~valid_q;
  assign last = (byte_cnt == CW'(IMG_BYTES - 1));

  // Stream is MSB first, so the byte is bit-reversed before landing in the image.
  always_comb begin
    rev = '0;
    for (int j = 0; j < 8; j++) begin
      rev[j] = spi_rx_data[7-j];
    end
  end

  // Bits past the end of the image fall off the top of the shift.
  assign ins = PIX'(rev) << {byte_cnt, 3'b000};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= COLLECT;
      valid_q    <= 1'b0;
      tcnt       <= '0;
      byte_taken <= 1'b0;
      img_data   <= '0;
      img_valid  <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      byte_cnt   <= '0;
    end else begin
      valid_q    <= spi_byte_valid;
      byte_taken <= acc;
      frame_err  <= 1'b0;
      unique case (state)
        COLLECT: begin
          if (acc) begin
            img_data <= img_data | ins;
            tcnt     <= '0;
            if (last) begin
              byte_cnt <= '0;
              state    <= FULL;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end else if (byte_cnt != '0) begin
            if (tcnt == TW'(TIMEOUT_CYCLES)) begin
              byte_cnt  <= '0;
              tcnt      <= '0;
              frame_err <= 1'b1;
              img_data  <= '0;
            end else begin
              tcnt <= tcnt + 1'b1;
            end
          end
        end
        FULL: begin
          if (img_ack && img_valid) begin
            img_valid <= 1'b0;
            overflow  <= 1'b0;
            img_data  <= '0;
            state     <= COLLECT;
          end else begin
            img_valid <= 1'b1;
            if (acc) overflow <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_image_frame_assembler.sv
// Randomized bench for image_frame_assembler with a byte-level reference model.
// Expected images are queued at issue time and checked by an independent monitor.
module tb_image_frame_assembler;

  localparam int W  = 30;
  localparam int H  = 30;
  localparam int N  = W * H;
  localparam int NB = 113;
  localparam int TO = 10000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   spi_rx_data;
  logic         spi_byte_valid;
  logic         byte_taken;
  logic [N-1:0] img_data;
  logic         img_valid;
  logic         img_ack;
  logic         frame_err;
  logic         overflow;
  logic [6:0]   byte_cnt;

  image_frame_assembler #(
    .IMG_W(W), .IMG_H(H), .IMG_BYTES(NB), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .spi_rx_data(spi_rx_data), .spi_byte_valid(spi_byte_valid),
    .byte_taken(byte_taken), .img_data(img_data), .img_valid(img_valid),
    .img_ack(img_ack), .frame_err(frame_err), .overflow(overflow),
    .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int taken_cnt = 0;
  int last_taken_cyc = 0;
  int ferr_cnt = 0;
  int ferr_cyc = 0;
  bit prev_valid = 1'b0;
  bit prev_ferr = 1'b0;

  logic [N-1:0] exp_q[$];
  logic [N-1:0] held_img = '0;
  logic [7:0]   cur[$];
  bit           m_full = 1'b0;
  bit           m_ovf = 1'b0;
  logic [7:0]   fb[NB];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: stream bit k = byte[k/8] bit (7 - k%8), truncated at N.
  task automatic model_byte(input logic [7:0] b);
    logic [N-1:0] img;
    logic [7:0]   bv;
    if (m_full) begin
      m_ovf = 1'b1;
    end else begin
      cur.push_back(b);
      if (cur.size() == NB) begin
        img = '0;
        for (int k = 0; k < N; k++) begin
          bv = cur[k/8];
          img[k] = bv[7 - (k % 8)];
        end
        exp_q.push_back(img);
        cur.delete();
        m_full = 1'b1;
      end
    end
  endtask

  function automatic int exp_cnt();
    return m_full ? 0 : cur.size();
  endfunction

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    model_byte(b);
    @(posedge clk);
    #1;
    spi_rx_data = b;
    spi_byte_valid = 1'b1;
    repeat (hold) @(posedge clk);
    #1 spi_byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frame(input int gmin, input int gmax);
    for (int i = 0; i < NB; i++) begin
      send_byte(fb[i], 1, $urandom_range(gmax, gmin));
    end
  endtask

  task automatic rand_fb();
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!img_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("img_valid_arrives", {63'd0, img_valid}, 64'd1);
  endtask

  task automatic do_ack();
    @(posedge clk);
    #1 img_ack = 1'b1;
    m_full = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1 img_ack = 1'b0;
    @(negedge clk);
    check("ack_valid_low", {63'd0, img_valid}, 64'd0);
    check("ack_ovf_low", {63'd0, overflow}, 64'd0);
    check("ack_img_zero", {63'd0, (img_data == '0)}, 64'd1);
  endtask

  // Monitor: pops the expected image whenever the DUT presents one.
  always @(negedge clk) begin
    cyc++;
    if (byte_taken) begin
      taken_cnt++;
      last_taken_cyc = cyc;
    end
    if (frame_err) begin
      ferr_cnt++;
      ferr_cyc = cyc;
      checks++;
      if (prev_ferr) begin
        errors++;
        $display("FAIL frame_err_width got 2+ cycles expected 1");
      end
    end
    if (img_valid && !prev_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL img_unexpected got valid expected none");
      end else begin
        held_img = exp_q.pop_front();
        checks++;
        if (img_data !== held_img) begin
          errors++;
          $display("FAIL img_data got %h.. expected %h.. (%0d bits differ)",
                   img_data[63:0], held_img[63:0],
                   $countones(img_data ^ held_img));
        end
      end
      checks++;
      if (cyc - last_taken_cyc != 1) begin
        errors++;
        $display("FAIL img_latency got %0d expected 1", cyc - last_taken_cyc);
      end
    end else if (img_valid && prev_valid && img_data !== held_img) begin
      errors++;
      $display("FAIL img_hold got %h.. expected %h..",
               img_data[63:0], held_img[63:0]);
    end
    prev_valid = img_valid;
    prev_ferr = frame_err;
  end

  initial begin
    int t0;
    int f0;
    int n;
    logic [N-1:0] one_img;
    spi_rx_data = '0;
    spi_byte_valid = 1'b0;
    img_ack = 1'b0;
    one_img = '0;
    one_img[0] = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_taken", {63'd0, byte_taken}, 64'd0);
    check("rst_valid", {63'd0, img_valid}, 64'd0);
    check("rst_ferr", {63'd0, frame_err}, 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_cnt", 64'(byte_cnt), 64'd0);
    check("rst_img", {63'd0, (img_data == '0)}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // All-ones frame, widely spaced bytes
    for (int i = 0; i < NB; i++) fb[i] = 8'hFF;
    t0 = taken_cnt;
    send_frame(20, 20);
    wait_valid();
    check("ff_taken", 64'(taken_cnt - t0), 64'd113);
    check("ff_all_ones", {63'd0, (img_data == '1)}, 64'd1);
    check("ff_ferr", 64'(ferr_cnt), 64'd0);
    check("ff_ovf", {63'd0, overflow}, 64'd0);
    do_ack();

    // Single leading bit
    for (int i = 0; i < NB; i++) fb[i] = 8'h00;
    fb[0] = 8'h80;
    send_frame(0, 3);
    wait_valid();
    check("bit0_only", {63'd0, (img_data == one_img)}, 64'd1);
    do_ack();

    // Last byte: high nibble kept, low nibble dropped
    for (int i = 0; i < NB; i++) fb[i] = 8'h00;
    fb[NB-1] = 8'hF5;
    send_frame(0, 2);
    wait_valid();
    check("tail_nibble", 64'(img_data[N-1:N-4]), 64'hF);
    check("tail_popcount", 64'($countones(img_data)), 64'd4);
    do_ack();

    // Random frames
    for (int f = 0; f < 3; f++) begin
      rand_fb();
      send_frame(0, 3);
      wait_valid();
      do_ack();
    end

    // Stalled partial frame
    f0 = ferr_cnt;
    for (int i = 0; i < 50; i++) send_byte(8'($urandom), 1, $urandom_range(3, 0));
    check("partial_cnt", 64'(byte_cnt), 64'(exp_cnt()));
    n = 0;
    while (ferr_cnt == f0 && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    cur.delete();
    check("timeout_pulses", 64'(ferr_cnt - f0), 64'd1);
    check("timeout_cnt", 64'(byte_cnt), 64'd0);
    check("timeout_img", {63'd0, (img_data == '0)}, 64'd1);
    check("timeout_window",
          {63'd0, (ferr_cyc - last_taken_cyc >= TO - 5 &&
                   ferr_cyc - last_taken_cyc <= TO + 5)}, 64'd1);
    rand_fb();
    send_frame(0, 2);
    wait_valid();
    do_ack();

    // Overflow bytes while image is held
    rand_fb();
    send_frame(0, 2);
    wait_valid();
    t0 = taken_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1, 2);
    @(negedge clk);
    check("ovf_taken", 64'(taken_cnt - t0), 64'd3);
    check("ovf_flag", {63'd0, overflow}, {63'd0, m_ovf});
    check("ovf_img_held", {63'd0, (img_data == held_img)}, 64'd1);
    check("ovf_valid", {63'd0, img_valid}, 64'd1);
    do_ack();
    rand_fb();
    send_frame(0, 2);
    wait_valid();
    do_ack();

    // Byte arriving in the same cycle as the ack is dropped silently
    rand_fb();
    send_frame(0, 1);
    wait_valid();
    t0 = taken_cnt;
    @(posedge clk);
    #1;
    spi_rx_data = 8'($urandom);
    spi_byte_valid = 1'b1;
    img_ack = 1'b1;
    m_full = 1'b0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    spi_byte_valid = 1'b0;
    img_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("coll_taken", 64'(taken_cnt - t0), 64'd1);
    check("coll_ovf", {63'd0, overflow}, 64'd0);
    check("coll_cnt", 64'(byte_cnt), 64'd0);
    check("coll_valid", {63'd0, img_valid}, 64'd0);

    // Held-high valid counts once, then reset mid-frame
    t0 = taken_cnt;
    send_byte(8'($urandom), 5, 2);
    @(negedge clk);
    check("hold_taken", 64'(taken_cnt - t0), 64'd1);
    check("hold_cnt", 64'(byte_cnt), 64'd1);
    for (int i = 0; i < 59; i++) send_byte(8'($urandom), 1, 0);
    repeat (2) @(negedge clk);
    check("mid_cnt", 64'(byte_cnt), 64'd60);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_cnt", 64'(byte_cnt), 64'd0);
    check("arst_img", {63'd0, (img_data == '0)}, 64'd1);
    check("arst_flags",
          {60'd0, byte_taken, img_valid, frame_err, overflow}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cur.delete();
    rand_fb();
    send_frame(0, 2);
    wait_valid();
    do_ack();

    repeat (3) @(negedge clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
